// File: rtl/noc_input_port.sv
// Wormhole router input stage: FWFT flit FIFO, XY route computation per packet,
// and hysteretic ON/OFF back-pressure toward the upstream router.
module noc_input_port #(
   parameter int FLIT_SIZE  = 8,
   parameter int OP_SIZE    = 3,
   parameter int DEPTH      = 8,
   parameter int X_ADDR     = 0,
   parameter int Y_ADDR     = 0,
   parameter int OFF_THRESH = 6,
   parameter int ON_THRESH  = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_en,
   input  logic [FLIT_SIZE-1:0]      flit_in,
   input  logic                      rd_en,
   output logic [FLIT_SIZE-1:0]      in_buf,
   output logic [OP_SIZE-1:0]        op_port,
   output logic                      ON_OFF_signal,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [1:0] T_HEAD = 2'b01;
   localparam logic [1:0] T_TAIL = 2'b11;
   localparam logic [1:0] XA = X_ADDR[1:0];
   localparam logic [1:0] YA = Y_ADDR[1:0];
   localparam logic [OP_SIZE-1:0] OP_N    = OP_SIZE'(0);
   localparam logic [OP_SIZE-1:0] OP_E    = OP_SIZE'(1);
   localparam logic [OP_SIZE-1:0] OP_S    = OP_SIZE'(2);
   localparam logic [OP_SIZE-1:0] OP_W    = OP_SIZE'(3);
   localparam logic [OP_SIZE-1:0] OP_L    = OP_SIZE'(4);
   localparam logic [OP_SIZE-1:0] OP_NONE = '1;

   typedef enum logic {IDLE, ACTIVE} state_t;

   logic [FLIT_SIZE-1:0] mem_q [DEPTH];
   logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]        count_q, count_d;
   state_t               state_q;
   logic [OP_SIZE-1:0]   op_q;
   logic                 on_q, err_q;

   logic [FLIT_SIZE-1:0] front;
   logic [1:0]           ftype;
   logic                 not_empty, full, pop, wr_acc;

   function automatic logic [OP_SIZE-1:0] xy_route(input logic [FLIT_SIZE-1:0] f);
      logic [1:0] dx, dy;
      dx = f[5:4];
      dy = f[3:2];
      if (dx > XA)      return OP_E;
      else if (dx < XA) return OP_W;
      else if (dy > YA) return OP_N;
      else if (dy < YA) return OP_S;
      else              return OP_L;
   endfunction

   assign not_empty = (count_q != '0);
   assign full      = (count_q == CW'(DEPTH));
   assign front     = not_empty ? mem_q[rd_ptr_q] : '0;
   assign ftype     = front[7:6];

   // In IDLE anything that is not a head is flushed; in ACTIVE the allocator pops.
   always_comb begin
      pop = 1'b0;
      if (not_empty) begin
         if (state_q == IDLE) pop = (ftype != T_HEAD);
         else                 pop = rd_en;
      end
   end

   assign wr_acc  = wr_en && (!full || pop);
   assign count_d = count_q + CW'(wr_acc) - CW'(pop);

   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wr_ptr_q] <= flit_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= IDLE;
         op_q     <= OP_NONE;
         on_q     <= 1'b1;
         err_q    <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)    rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
         if (wr_en && !wr_acc) err_q <= 1'b1;
         if (state_q == IDLE && not_empty && ftype[1]) err_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (not_empty && ftype == T_HEAD) begin
                  state_q <= ACTIVE;
                  op_q    <= xy_route(front);
               end
            end
            ACTIVE: begin
               if (pop && ftype == T_TAIL) begin
                  state_q <= IDLE;
                  op_q    <= OP_NONE;
               end
            end
            default: state_q <= IDLE;
         endcase
         // Hysteresis: between the thresholds the previous level is kept.
         if (count_d >= CW'(OFF_THRESH))     on_q <= 1'b0;
         else if (count_d <= CW'(ON_THRESH)) on_q <= 1'b1;
      end
   end

   assign in_buf        = front;
   assign op_port       = op_q;
   assign ON_OFF_signal = on_q;
   assign count         = count_q;
   assign err           = err_q;

endmodule

// File: tb/tb_noc_input_port.sv
// Bench for noc_input_port: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_noc_input_port;

   localparam int DEPTH = 8;

   logic       clk = 0;
   logic       rst_n = 0;
   logic       wr_en = 0;
   logic [7:0] flit_in = 0;
   logic       rd_en = 0;
   logic [7:0] in_buf;
   logic [2:0] op_port;
   logic       ON_OFF_signal;
   logic [3:0] count;
   logic       err;

   noc_input_port #(.FLIT_SIZE(8), .OP_SIZE(3), .DEPTH(DEPTH), .X_ADDR(1), .Y_ADDR(1),
                    .OFF_THRESH(6), .ON_THRESH(2)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .flit_in(flit_in), .rd_en(rd_en),
      .in_buf(in_buf), .op_port(op_port), .ON_OFF_signal(ON_OFF_signal),
      .count(count), .err(err));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [7:0] q[$];
   bit         m_active;
   logic [2:0] m_op;
   bit         m_on;
   bit         m_err;

   function automatic logic [2:0] ref_route(input logic [7:0] f);
      int dx, dy;
      dx = f[5:4];
      dy = f[3:2];
      if (dx > 1) return 3'b001;
      if (dx < 1) return 3'b011;
      if (dy > 1) return 3'b000;
      if (dy < 1) return 3'b010;
      return 3'b100;
   endfunction

   task automatic model_reset();
      q.delete();
      m_active = 0;
      m_op = 3'b111;
      m_on = 1;
      m_err = 0;
   endtask

   task automatic model_step(input bit we, input logic [7:0] fl, input bit rd);
      int n;
      bit popped;
      logic [7:0] f;
      n = q.size();
      popped = 0;
      if (n > 0) begin
         f = q[0];
         if (!m_active) begin
            if (f[7:6] == 2'b01) begin
               m_active = 1;
               m_op = ref_route(f);
            end else begin
               popped = 1;
               if (f[7]) m_err = 1;
            end
         end else if (rd) begin
            popped = 1;
            if (f[7:6] == 2'b11) begin
               m_active = 0;
               m_op = 3'b111;
            end
         end
      end
      if (popped) void'(q.pop_front());
      if (we) begin
         if (n < DEPTH || popped) q.push_back(fl);
         else m_err = 1;
      end
      if (q.size() >= 6) m_on = 0;
      else if (q.size() <= 2) m_on = 1;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".in_buf"}, in_buf, (q.size() > 0) ? q[0] : 8'h00);
      chk({tag, ".op_port"}, {5'b0, op_port}, {5'b0, m_op});
      chk({tag, ".count"}, {4'b0, count}, 8'(q.size()));
      chk({tag, ".on_off"}, {7'b0, ON_OFF_signal}, {7'b0, m_on});
      chk({tag, ".err"}, {7'b0, err}, {7'b0, m_err});
   endtask

   task automatic step(input bit we, input logic [7:0] fl, input bit rd);
      wr_en = we;
      flit_in = fl;
      rd_en = rd;
      @(posedge clk);
      model_step(we, fl, rd);
      #1;
      wr_en = 0;
      rd_en = 0;
      flit_in = 0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 0;
      #1;
      model_reset();
      chk("reset.in_buf", in_buf, 8'h00);
      chk("reset.op_port", {5'b0, op_port}, 8'h07);
      chk("reset.count", {4'b0, count}, 8'h00);
      chk("reset.on_off", {7'b0, ON_OFF_signal}, 8'h01);
      chk("reset.err", {7'b0, err}, 8'h00);
      @(negedge clk);
      rst_n = 1;
   endtask

   typedef struct {
      bit         we;
      logic [7:0] fl;
      bit         rd;
      logic [7:0] ib;
      logic [2:0] op;
      logic [3:0] cnt;
      bit         on;
      bit         er;
   } vec_t;

   vec_t tv[6];

   int g_left = 0;
   function automatic logic [7:0] gen_flit();
      logic [7:0] f;
      if ($urandom_range(0, 15) == 0) return 8'($urandom);
      if (g_left == 0) begin
         f = {2'b01, 6'($urandom)};
         g_left = $urandom_range(1, 4);
      end else if (g_left == 1) begin
         f = {2'b11, 6'($urandom)};
         g_left = 0;
      end else begin
         f = {2'b10, 6'($urandom)};
         g_left--;
      end
      return f;
   endfunction

   initial begin
      logic [7:0] nf;
      bit we, rd;
      model_reset();
      #3;
      rst_n = 1;

      // Packet E with rd_en held: head, body, tail
      tv[0] = '{1'b1, 8'h64, 1'b1, 8'h64, 3'b111, 4'd1, 1'b1, 1'b0};
      tv[1] = '{1'b1, 8'h80, 1'b1, 8'h64, 3'b001, 4'd2, 1'b1, 1'b0};
      tv[2] = '{1'b1, 8'hC0, 1'b1, 8'h80, 3'b001, 4'd2, 1'b1, 1'b0};
      tv[3] = '{1'b0, 8'h00, 1'b1, 8'hC0, 3'b001, 4'd1, 1'b1, 1'b0};
      tv[4] = '{1'b0, 8'h00, 1'b1, 8'h00, 3'b111, 4'd0, 1'b1, 1'b0};
      tv[5] = '{1'b0, 8'h00, 1'b1, 8'h00, 3'b111, 4'd0, 1'b1, 1'b0};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(tv[i].we, tv[i].fl, tv[i].rd);
         chk($sformatf("tv%0d.in_buf", i), in_buf, tv[i].ib);
         chk($sformatf("tv%0d.op_port", i), {5'b0, op_port}, {5'b0, tv[i].op});
         chk($sformatf("tv%0d.count", i), {4'b0, count}, {4'b0, tv[i].cnt});
         chk($sformatf("tv%0d.on_off", i), {7'b0, ON_OFF_signal}, {7'b0, tv[i].on});
         chk($sformatf("tv%0d.err", i), {7'b0, err}, {7'b0, tv[i].er});
      end

      // Local, north and west packets
      begin
         logic [7:0] heads[3];
         logic [2:0] routes[3];
         heads = '{8'h54, 8'h5C, 8'h44};
         routes = '{3'b100, 3'b000, 3'b011};
         for (int p = 0; p < 3; p++) begin
            step(1, heads[p], 0);
            step(1, 8'hC0, 0);
            chk($sformatf("route%0d", p), {5'b0, op_port}, {5'b0, routes[p]});
            step(0, 0, 1);
            step(0, 0, 1);
            chk($sformatf("route%0d.done", p), {5'b0, op_port}, 8'h07);
            chk($sformatf("route%0d.cnt", p), {4'b0, count}, 8'h00);
         end
      end

      // Fill, overflow, drain with hysteresis
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(1, (i == 0) ? 8'h54 : 8'h80 + 8'(i), 0);
         if (i == 4) chk("fill5.on_off", {7'b0, ON_OFF_signal}, 8'h01);
         if (i == 5) chk("fill6.on_off", {7'b0, ON_OFF_signal}, 8'h00);
      end
      chk("full.count", {4'b0, count}, 8'h08);
      chk("full.err", {7'b0, err}, 8'h00);
      step(1, 8'hC0, 0);
      chk("ovf.count", {4'b0, count}, 8'h08);
      chk("ovf.err", {7'b0, err}, 8'h01);
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 1);
         if (i == 4) chk("drain3.on_off", {7'b0, ON_OFF_signal}, 8'h00);
         if (i == 5) chk("drain2.on_off", {7'b0, ON_OFF_signal}, 8'h01);
      end
      chk("drain.count", {4'b0, count}, 8'h02);

      // Headless body into empty FIFO
      do_reset();
      step(1, 8'h80, 0);
      chk("body.in_buf", in_buf, 8'h80);
      step(0, 0, 0);
      chk("body.count", {4'b0, count}, 8'h00);
      chk("body.err", {7'b0, err}, 8'h01);
      chk("body.op_port", {5'b0, op_port}, 8'h07);

      // Full FIFO with simultaneous write and pop
      do_reset();
      for (int i = 0; i < 8; i++) step(1, (i == 0) ? 8'h64 : 8'h80 + 8'(i), 0);
      step(1, 8'h9A, 1);
      chk("simul.count", {4'b0, count}, 8'h08);
      chk("simul.err", {7'b0, err}, 8'h00);
      for (int i = 0; i < 7; i++) step(0, 0, 1);
      chk("simul.in_buf", in_buf, 8'h9A);
      chk("simul.count1", {4'b0, count}, 8'h01);

      // Reset mid-packet with 3 flits buffered
      do_reset();
      step(1, 8'h64, 0);
      step(1, 8'h81, 0);
      step(1, 8'h82, 0);
      chk("mid.count", {4'b0, count}, 8'h03);
      chk("mid.op_port", {5'b0, op_port}, 8'h01);
      do_reset();
      step(1, 8'h5C, 0);
      step(1, 8'hC0, 0);
      chk("post.op_port", {5'b0, op_port}, 8'h00);
      chk_model("post");

      // Randomized run against the reference model
      do_reset();
      g_left = 0;
      for (int c = 0; c < 600; c++) begin
         if (c == 300) do_reset();
         we = ($urandom_range(0, 9) < (ON_OFF_signal ? 7 : 3));
         rd = ($urandom_range(0, 9) < 6);
         nf = we ? gen_flit() : 8'h00;
         step(we, nf, rd);
         chk_model($sformatf("rnd%0d", c));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
